regfile_sweep: RTL and testbench

Parametrised three-port register file for the 5-stage MIPS pipeline: two combinational read ports, one write port, plus a registered debug read port. Writes commit on the rising edge of `clk`, and same-cycle write-to-read bypass replaces the falling-edge write trick. Reset does not clear the array in parallel. Instead, a clear-sweep state machine zeroes one entry per cycle, so the array stays inferable as RAM. `busy` holds off the pipeline until the sweep finishes.

---
 rtl/regfile_sweep.sv | 104 ++++++++++
 tb/tb_regfile_sweep.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_sweep.sv
// Three-port register file with combinational reads, bypassed write and a
// registered debug port; reset zeroes the array one entry per cycle.
module regfile_sweep #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  clr_addr_reg, clr_addr_next;
  logic [DATA_W-1:0]  rf [DEPTH];

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  // The sweep and the pipeline share the single array write port.
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    wr_en         = 1'b0;
    wr_addr       = wa3;
    wr_data       = wd3;
    case (state_reg)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr_reg;
        wr_data = '0;
        if (clr_addr_reg == ADDR_W'(DEPTH-1)) begin
          state_next    = RUN;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr_reg + ADDR_W'(1);
        end
      end
      RUN: begin
        wr_en = we3 && !((R0_ZERO != 0) && (wa3 == '0));
      end
      default: state_next = CLEAR;
    endcase
    if (reset) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  // Registered read sees the array before this edge's write; no bypass here.
  always_ff @(posedge clk) begin
    if (reset || state_reg == CLEAR || ((R0_ZERO != 0) && (dbg_addr == '0)))
      dbg_data <= '0;
    else
      dbg_data <= rf[dbg_addr];
  end

  assign busy = (state_reg == CLEAR);

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];

  assign ra[0] = ra1;
  assign ra[1] = ra2;
  assign rd1   = rd[0];
  assign rd2   = rd[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_read
    always_comb begin
      rd[gi] = rf[ra[gi]];
      if (state_reg == CLEAR)
        rd[gi] = '0;
      else if ((R0_ZERO != 0) && (ra[gi] == '0))
        rd[gi] = '0;
      else if ((BYPASS != 0) && we3 && (wa3 == ra[gi]))
        rd[gi] = wd3;
    end
  end
endmodule

// File: tb/tb_regfile_sweep.sv
// Directed bench for regfile_sweep: default instance plus one with r0
// writable and no bypass, both driven by the same stimulus.
module tb_regfile_sweep;
  logic        clk = 1'b0;
  logic        reset;
  logic        we3;
  logic [4:0]  wa3, ra1, ra2, dbg_addr;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, dbg_data;
  logic        busy;
  logic [31:0] nb_rd1, nb_rd2, nb_dbg_data;
  logic        nb_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sweep dut (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  regfile_sweep #(.R0_ZERO(0), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data), .busy(nb_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  da;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_dbg;
    logic [31:0] e_nb_rd1;
    logic [31:0] e_nb_dbg;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  5'd7,  32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,  5'd0,  32'h0,        32'h12345678, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd6,  5'd5,  32'hCAFEF00D, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 5'd31, 32'hCAFEF00D, 32'h0,        32'h0,        32'hCAFEF00D, 32'h0};
    vecs[8] = '{1'b1, 5'd31, 32'h80000001, 5'd30, 5'd31, 5'd31, 32'h0,        32'h80000001, 32'h0,        32'h0,        32'h0};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd3,  5'd31, 32'h80000001, 32'h0,        32'h80000001, 32'h80000001, 32'h80000001};

    reset = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0;
    ra1 = 5'd3; ra2 = 5'd0; dbg_addr = 5'd0;
    repeat (3) step();
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_dbg", dbg_data, 32'h0);
    check("reset_rd1", rd1, 32'h0);

    // Release reset while hammering r3; every write during the sweep is lost.
    reset = 1'b0; we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hAAAA5555;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check($sformatf("sweep_busy_%0d", i), {31'b0, busy}, 32'd1);
      check($sformatf("sweep_rd1_%0d", i), rd1, 32'h0);
      step();
    end
    check("sweep_done_busy", {31'b0, busy}, 32'd0);
    check("sweep_done_nb_busy", {31'b0, nb_busy}, 32'd0);
    we3 = 1'b0;
    @(negedge clk);
    check("r3_after_clear", rd1, 32'h0);
    check("r3_after_clear_nb", nb_rd1, 32'h0);
    $display("sweep released: busy=%0b rd1(r3)=%h", busy, rd1);

    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      step();
      check($sformatf("dbg_sweep_%0d", i), dbg_data, 32'h0);
      check($sformatf("dbg_sweep_nb_%0d", i), nb_dbg_data, 32'h0);
    end

    for (int v = 0; v < 10; v++) begin
      we3 = vecs[v].we; wa3 = vecs[v].wa; wd3 = vecs[v].wd;
      ra1 = vecs[v].a1; ra2 = vecs[v].a2; dbg_addr = vecs[v].da;
      @(negedge clk);
      check($sformatf("vec%0d_rd1", v), rd1, vecs[v].e_rd1);
      check($sformatf("vec%0d_rd2", v), rd2, vecs[v].e_rd2);
      check($sformatf("vec%0d_nb_rd1", v), nb_rd1, vecs[v].e_nb_rd1);
      step();
      check($sformatf("vec%0d_dbg", v), dbg_data, vecs[v].e_dbg);
      check($sformatf("vec%0d_nb_dbg", v), nb_dbg_data, vecs[v].e_nb_dbg);
      $display("vec %0d: we=%0b wa=%0d wd=%h ra1=%0d ra2=%0d rd1=%h rd2=%h dbg=%h",
               v, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].a1, vecs[v].a2, rd1, rd2, dbg_data);
    end
    we3 = 1'b0;

    for (int i = 1; i < 32; i++) begin
      we3 = 1'b1; wa3 = 5'(i); wd3 = 32'(i);
      step();
    end
    we3 = 1'b0; ra1 = 5'd17; ra2 = 5'd0;
    @(negedge clk);
    check("fill_r17", rd1, 32'd17);
    check("fill_r17_nb", nb_rd1, 32'd17);
    check("fill_r0_nb", nb_rd2, 32'hFFFFFFFF);
    $display("fill done: r17=%h nb_r0=%h", rd1, nb_rd2);

    // Single-cycle reset mid-run must restart the whole sweep.
    reset = 1'b1; dbg_addr = 5'd17;
    step();
    check("midrun_reset_dbg", dbg_data, 32'h0);
    check("midrun_reset_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check($sformatf("resweep_busy_%0d", i), {31'b0, busy}, 32'd1);
      step();
    end
    check("resweep_done_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i); dbg_addr = 5'(i);
      @(negedge clk);
      check($sformatf("cleared_rd1_%0d", i), rd1, 32'h0);
      check($sformatf("cleared_rd2_%0d", i), rd2, 32'h0);
      check($sformatf("cleared_nb_rd1_%0d", i), nb_rd1, 32'h0);
      step();
      check($sformatf("cleared_dbg_%0d", i), dbg_data, 32'h0);
      check($sformatf("cleared_nb_dbg_%0d", i), nb_dbg_data, 32'h0);
    end
    $display("re-sweep done: busy=%0b", busy);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
